// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 codes, controller FSM states and store byte-enable helper
package riscv_mem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
   // Lanes touched by an access; undefined funct3 codes behave as words.
   function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] a);
      case (f3)
         F3_B, F3_BU: byte_en = 4'b0001 << a;
         F3_H, F3_HU: byte_en = a[1] ? 4'b1100 : 4'b0011;
         F3_W:        byte_en = 4'b1111;
         default:     byte_en = 4'b1111;
      endcase
   endfunction
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a RAM word and sign- or zero-extends it
//   i_word    : full 32-bit word read from memory
//   i_addr_lo : byte offset within the word (addr[1:0])
//   i_funct3  : RV32 load funct3 (size and signedness)
//   o_data    : extended load result
module load_extend
   import riscv_mem_pkg::*;
(
   input  logic [31:0] i_word,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   assign w_byte = i_word[{i_addr_lo, 3'b000} +: 8];
   assign w_half = i_addr_lo[1] ? i_word[31:16] : i_word[15:0];
   always_comb begin
      o_data = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
               (i_funct3 == F3_BU) ? {24'd0, w_byte} :
               (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
               (i_funct3 == F3_HU) ? {16'd0, w_half} : i_word;
   end
endmodule

// File: rtl/multi_cycle_mem_ctrl.sv
// multi_cycle_mem_ctrl: unified I/D memory for the multi-cycle RV32 core with fixed access latency
//   i_clk, i_rst_n        : clock (rising edge), asynchronous active-low reset
//   i_req_valid/o_req_ready : request handshake; requests only taken in IDLE
//   i_req_we, i_req_addr, i_req_wdata, i_req_funct3 : store flag, byte address, LSB-aligned data, size/sign
//   o_rsp_valid           : one-cycle response pulse
//   o_rsp_rdata           : extended load data (0 for stores), held until the next response
//   o_rsp_fault           : misaligned-access flag, meaningful with o_rsp_valid
// Optional: define MEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses instead of force-aligning them.
module multi_cycle_mem_ctrl
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1,
   parameter int CNT_W       = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [31:0] i_req_wdata,
   input  logic [2:0]  i_req_funct3,
   output logic        o_rsp_valid,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_fault
);
   state_t              r_state, w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_we;
   logic [ADDR_W+1:0]   r_addr;
   logic [31:0]         r_wdata;
   logic [2:0]          r_funct3;
   logic [31:0]         r_rdata;
   logic                r_fault;
   logic [31:0]         r_mem [2**ADDR_W];
   logic                w_accept, w_done, w_mis, w_unused;
   logic [3:0]          w_be;
   logic [31:0]         w_word, w_load, w_lane_data, w_mask;
   assign w_unused    = ^i_req_addr[31:ADDR_W+2];
   assign w_accept    = i_req_valid && (r_state == ST_IDLE);
   assign w_done      = (r_state == ST_ACCESS) && (r_cnt == CNT_W'(WAIT_CYCLES));
   assign w_word      = r_mem[r_addr[ADDR_W+1:2]];
   assign w_be        = byte_en(r_funct3, r_addr[1:0]);
   assign w_mask      = {{8{w_be[3]}}, {8{w_be[2]}}, {8{w_be[1]}}, {8{w_be[0]}}};
   // Replicating the store data puts it on every lane; the byte enables pick the right one.
   assign w_lane_data = (r_funct3[1:0] == F3_B[1:0]) ? {4{r_wdata[7:0]}} :
                        (r_funct3[1:0] == F3_H[1:0]) ? {2{r_wdata[15:0]}} : r_wdata;
`ifdef MEM_MISALIGN_TRAP_EN
   assign w_mis = r_funct3[1] ? (r_addr[1:0] != 2'b00) : (r_funct3[0] & r_addr[0]);
`else
   assign w_mis = 1'b0;
`endif
   load_extend u_load_extend (
      .i_word    (w_word),
      .i_addr_lo (r_addr[1:0]),
      .i_funct3  (r_funct3),
      .o_data    (w_load)
   );
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:   w_next = i_req_valid ? ST_ACCESS : ST_IDLE;
         ST_ACCESS: w_next = w_done ? ST_RESP : ST_ACCESS;
         default:   w_next = ST_IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt    <= '0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_funct3 <= '0;
         r_rdata  <= '0;
         r_fault  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_cnt    <= '0;
            r_we     <= i_req_we;
            r_addr   <= i_req_addr[ADDR_W+1:0];
            r_wdata  <= i_req_wdata;
            r_funct3 <= i_req_funct3;
         end else if (r_state == ST_ACCESS) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_done) begin
            r_rdata <= (r_we || w_mis) ? 32'd0 : w_load;
            r_fault <= w_mis;
         end
      end
   end
   // RAM is not reset; a reset during ACCESS drops the state so the write never fires.
   always_ff @(posedge i_clk) begin
      if (w_done && r_we && !w_mis) r_mem[r_addr[ADDR_W+1:2]] <= (w_word & ~w_mask) | (w_lane_data & w_mask);
   end
   assign o_req_ready = (r_state == ST_IDLE);
   assign o_rsp_valid = (r_state == ST_RESP);
   assign o_rsp_rdata = r_rdata;
   assign o_rsp_fault = r_fault;
endmodule

// File: tb/tb_multi_cycle_mem_ctrl.sv
// tb_multi_cycle_mem_ctrl: randomized and directed checks of the memory controller against a queue/array model
module tb_multi_cycle_mem_ctrl;
   localparam int W = 1;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [2:0]  req_funct3 = '0;
   logic        req_ready, rsp_valid, rsp_fault;
   logic [31:0] rsp_rdata;

   multi_cycle_mem_ctrl #(.ADDR_W(10), .WAIT_CYCLES(W), .CNT_W(4)) dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req_valid  (req_valid),
      .o_req_ready  (req_ready),
      .i_req_we     (req_we),
      .i_req_addr   (req_addr),
      .i_req_wdata  (req_wdata),
      .i_req_funct3 (req_funct3),
      .o_rsp_valid  (rsp_valid),
      .o_rsp_rdata  (rsp_rdata),
      .o_rsp_fault  (rsp_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
      int          due;
   } req_t;

   req_t        q[$];
   logic [31:0] mem_m [1024];
   int          errors = 0, checks = 0, edge_cnt = 0, acc_cnt = 0;
   logic [31:0] hold = '0, last_rdata = '0;
   logic        last_fault = 1'b0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference: one access at a time, applied when its response is due.
   task automatic model(input req_t r, output logic [31:0] rd, output logic fl);
      logic [31:0] w, v, m;
      int          sh;
      logic        mis;
      w   = mem_m[r.a[11:2]];
      mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      if (r.f[1:0] == 2'b01) mis = r.a[0];
      else if (r.f[1]) mis = (r.a[1:0] != 2'b00);
`endif
      if (r.f[1:0] == 2'b00) begin
         sh = 8 * int'(r.a[1:0]);
         m  = 32'hFF;
      end else if (r.f[1:0] == 2'b01) begin
         sh = 16 * int'(r.a[1]);
         m  = 32'hFFFF;
      end else begin
         sh = 0;
         m  = 32'hFFFF_FFFF;
      end
      fl = mis;
      rd = '0;
      if (r.we) begin
         if (!mis) mem_m[r.a[11:2]] = (w & ~(m << sh)) | ((r.d & m) << sh);
      end else if (!mis) begin
         v = (w >> sh) & m;
         if (!r.f[2] && m != 32'hFFFF_FFFF && v > (m >> 1)) v = v | ~m;
         rd = v;
      end
   endtask

   always @(posedge clk) edge_cnt++;

   always @(negedge clk) begin
      logic [31:0] rd;
      logic        fl, exp_ready, exp_valid;
      req_t        r;
      if (!rst_n) begin
         q.delete();
         hold = '0;
         chk("reset_ready", {31'd0, req_ready}, 32'd1);
         chk("reset_valid", {31'd0, rsp_valid}, 32'd0);
         chk("reset_rdata", rsp_rdata, 32'd0);
         chk("reset_fault", {31'd0, rsp_fault}, 32'd0);
      end else begin
         exp_ready = (q.size() == 0);
         exp_valid = (q.size() != 0) && (q[0].due == edge_cnt);
         chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
         chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
         if (exp_valid) begin
            model(q[0], rd, fl);
            void'(q.pop_front());
            hold = rd;
            chk("rsp_rdata", rsp_rdata, rd);
            chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, fl});
         end else begin
            chk("rdata_hold", rsp_rdata, hold);
         end
         if (rsp_valid) begin
            last_rdata = rsp_rdata;
            last_fault = rsp_fault;
         end
         if (req_valid && exp_ready) begin
            r.we  = req_we;
            r.a   = req_addr;
            r.d   = req_wdata;
            r.f   = req_funct3;
            r.due = edge_cnt + W + 2;
            q.push_back(r);
            acc_cnt++;
         end
      end
   end

   // Present a request and hold it until accepted; returns 2 time units after the accepting edge.
   task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
      int start;
      start      = acc_cnt;
      req_we     = we;
      req_addr   = a;
      req_wdata  = d;
      req_funct3 = f;
      req_valid  = 1'b1;
      for (int i = 0; i < 100 && acc_cnt == start; i++) begin
         @(negedge clk);
         #1;
      end
      if (acc_cnt == start) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: addr %h never accepted", a);
      end
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic expect_last(input string name, input logic [31:0] v, input logic fl);
      req_valid = 1'b0;
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_drain: %0d responses outstanding", name, q.size());
      end
      @(posedge clk);
      #2;
      chk(name, last_rdata, v);
      chk({name, "_fault"}, {31'd0, last_fault}, {31'd0, fl});
   endtask

   initial begin
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #2;
      for (int i = 0; i < 16; i++) req(1'b1, i * 4, $urandom, 3'b010);
      req(1'b1, 32'h10, 32'h1111_1111, 3'b010);
      req(1'b1, 32'h10, 32'hAAAA_5555, 3'b010);
      req_valid = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #2;
      req(1'b0, 32'h10, 32'h0, 3'b010);
      expect_last("reset_drops_store", 32'h1111_1111, 1'b0);
      req(1'b1, 32'h20, 32'hDEAD_BEEF, 3'b010);
      req(1'b0, 32'h20, 32'h0, 3'b010);
      expect_last("lw_roundtrip", 32'hDEAD_BEEF, 1'b0);
      req(1'b1, 32'h20, 32'h0, 3'b010);
      req(1'b1, 32'h21, 32'h80, 3'b000);
      req(1'b0, 32'h20, 32'h0, 3'b010);
      expect_last("sb_merge", 32'h0000_8000, 1'b0);
      chk("model_sb_word", mem_m[8], 32'h0000_8000);
      req(1'b0, 32'h21, 32'h0, 3'b000);
      expect_last("lb_sign", 32'hFFFF_FF80, 1'b0);
      req(1'b0, 32'h21, 32'h0, 3'b100);
      expect_last("lbu_zero", 32'h0000_0080, 1'b0);
      req(1'b0, 32'h20, 32'h0, 3'b001);
      expect_last("lh_sign", 32'hFFFF_8000, 1'b0);
      req(1'b1, 32'h1000, 32'h1234, 3'b010);
      req(1'b0, 32'h0, 32'h0, 3'b010);
      expect_last("wrap", 32'h0000_1234, 1'b0);
      req(1'b1, 32'h20, 32'hA5A5_A5A5, 3'b010);
      req(1'b0, 32'h22, 32'h0, 3'b010);
`ifdef MEM_MISALIGN_TRAP_EN
      expect_last("lw_misaligned", 32'h0, 1'b1);
`else
      expect_last("lw_misaligned", 32'hA5A5_A5A5, 1'b0);
`endif
      req(1'b1, 32'h23, 32'h0000_BEEF, 3'b001);
      req(1'b0, 32'h20, 32'h0, 3'b010);
`ifdef MEM_MISALIGN_TRAP_EN
      expect_last("sh_misaligned", 32'hA5A5_A5A5, 1'b0);
`else
      expect_last("sh_misaligned", 32'hBEEF_A5A5, 1'b0);
`endif
      for (int n = 0; n < 400; n++) begin
         logic [31:0] a;
         a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
         req(1'($urandom_range(0, 1)), a, $urandom, 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(1);
      for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL final_drain: %0d responses outstanding", q.size());
      end
      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: simulation did not complete");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
